scu_dsp_dma_ctrl: RTL and testbench
===================================

# scu_dsp_dma_ctrl

Sequences the SCU DSP's per-word DMA handshake onto the shared SCU external bus. It holds the DSP's read/write address registers RA0/WA0, which the DSP loads with D1-bus strobes. For each word the DSP requests, it arbitrates for the bus, performs the access and acknowledges the DSP. On the last word it signals DMA end and writes the advanced address back to RA0 or WA0. It sits between the DSP core and the SCU bus arbiter.

## Interface
Parameters:
- ADDR_W, 25, word-address width; bus byte address is {addr, 2'b00}.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
- DSO  in  32  DSP D1-bus value.
- RA0W  in  1  load RA0 <= DSO[ADDR_W-1:0].
- WA0W  in  1  load WA0 <= DSO[ADDR_W-1:0].
- ADD  in  3  address step code, sampled at transfer start.
- DSP_REQ  in  1  DSP word request; level-sampled, one pulse per word.
- DSP_WE  in  1  direction, sampled at transfer start: 1 = DSP→bus (uses WA0), 0 = bus→DSP (uses RA0).
- DSP_LAST  in  1  current word is the final word.
- DSP_DI  in  32  word from DSP for bus writes.
- DSP_DO  out  32  word read from the bus; reset 0.
- DSP_ACK  out  1  one-CE-cycle word acknowledge; reset 0.
- DSP_END  out  1  one-CE-cycle transfer complete; reset 0.
- BUS_REQ  out  1  bus request to arbiter; reset 0.
- BUS_GNT  in  1  bus grant.
- BUS_A  out  ADDR_W+2  byte address; reset 0.
- BUS_DO  out  32  write data; reset 0.
- BUS_DI  in  32  read data.
- BUS_WE  out  1  write strobe qualifier; reset 0.
- BUS_CS  out  1  access strobe; reset 0.
- BUS_RDY  in  1  access complete.
- BUSY  out  1  transfer in progress; reset 0.

## Operation
- Registers RA0 and WA0 (ADDR_W bits, reset 0) have a working counter WADR and a latched step STEP.
- Word step: STEP = 0 if ADD=0, else 1 << (ADD-1). This gives 0, 1, 2, 4, 8, 16, 32 or 64 words.
- WADR += STEP after each word, modulo 2^ADDR_W, with silent wrap-around.
- States:
  - IDLE: BUSY=0. On DSP_REQ, latch DIR=DSP_WE, STEP, and WADR = DIR ? WA0 : RA0, then go to ARB. BUSY stays 1 until END completes.
  - ARB: BUS_REQ=1. On BUS_GNT, go to ACC.
  - ACC: BUS_REQ=1, BUS_CS=1, BUS_A={WADR,2'b00}, BUS_WE=DIR, BUS_DO=DSP_DI (captured on ACC entry). On BUS_RDY: if DIR=0, DSP_DO <= BUS_DI; go to ACK.
  - ACK: DSP_ACK=1 for one CE cycle and WADR advances. BUS_REQ drops. If the word carried DSP_LAST (captured at request), go to END; else go to WAIT.
  - WAIT: on DSP_REQ, go to ARB. DIR, STEP and WADR are retained, not re-sampled.
  - END: DSP_END=1 for one CE cycle. Write WADR back to WA0 if DIR=1, else to RA0. Go to IDLE.
- RA0W/WA0W are accepted in any state. They update the architectural register only; the working WADR is unaffected.
- A simultaneous RA0W/WA0W and END write-back to the same register resolves in favour of the strobe.
- BUS_GNT removed during ACC has no effect; the access completes on BUS_RDY.
- DSP_REQ in ARB, ACC, ACK or END is ignored; the DSP issues the next request only after ACK.
- Reset asserted mid-transfer clears every register and output immediately to its reset value and returns to IDLE. No END is produced.

## Timing
- CE cycles throughout.
- DSP_REQ sampled in IDLE → BUS_REQ high the next cycle.
- GNT sampled → BUS_CS high the next cycle.
- RDY sampled → DSP_ACK the next cycle, with DSP_DO valid in that same cycle.
- Minimum per word: 4 cycles (REQ→ARB→ACC→ACK) with GNT and RDY both immediate.
- END follows ACK of the last word by 1 cycle. BUSY falls the cycle after END.
- BUS_A, BUS_WE and BUS_DO are stable for the whole ACC state.
- All outputs are registered.

## Test plan
- Read, ADD=1, RA0 loaded 0x100 via RA0W. Three requests, LAST on the third, GNT/RDY immediate → BUS_A = 0x400, 0x404, 0x408. Three ACKs with DSP_DO = BUS_DI, one END, RA0 = 0x103.
- Write, ADD=0, WA0=0x20, two words → both BUS_A = 0x80 with BUS_WE=1. BUS_DO matches DSP_DI per word. WA0 stays 0x20.
- Write, ADD=7, WA0=0x1FFFFC0 (ADDR_W=25), two words → second address wraps to 0x0 word. WA0 = 0x0000040 after END.
- GNT delayed 5 cycles and RDY delayed 3 → BUS_REQ held 5+ cycles, BUS_CS held until RDY, exactly one ACK per word.
- RA0W with DSO=0x55 during ACC of a read → current access uses the old WADR. RA0 = 0x55 after END (strobe on END cycle also wins).
- RST pulse during ACC → all outputs 0 within the same cycle, state IDLE, RA0/WA0 = 0, no ACK/END. A new DSP_REQ then starts cleanly.

Source files
------------

// File: rtl/scu_dsp_dma_ctrl.sv
// ---------------------------------------------------------------------------
// scu_dsp_dma_ctrl
//
// Word-by-word DMA sequencer between the SCU DSP core and the shared SCU
// external bus. Holds the DSP read/write address registers RA0/WA0. For each
// word the DSP requests, it arbitrates for the bus, performs one access and
// acknowledges the DSP. After the last word it pulses DSP_END and writes the
// advanced working address back to RA0 (reads) or WA0 (writes).
//
// Parameters
//   ADDR_W    word-address width; bus byte address is {addr, 2'b00}
//
// Ports
//   CLK       system clock
//   RST       asynchronous active-high reset
//   CE        clock enable; all state advances only on CE edges
//   DSO       DSP D1-bus value, source for RA0/WA0 loads
//   RA0W      load RA0 from DSO
//   WA0W      load WA0 from DSO
//   ADD       address step code, sampled at transfer start
//   DSP_REQ   per-word request from the DSP
//   DSP_WE    direction, sampled at transfer start (1 = DSP to bus)
//   DSP_LAST  current word is the final word of the transfer
//   DSP_DI    write data from the DSP
//   DSP_DO    read data to the DSP
//   DSP_ACK   one-cycle word acknowledge
//   DSP_END   one-cycle transfer-complete pulse
//   BUS_REQ   bus request to the SCU arbiter
//   BUS_GNT   bus grant from the arbiter
//   BUS_A     bus byte address
//   BUS_DO    bus write data
//   BUS_DI    bus read data
//   BUS_WE    bus write qualifier
//   BUS_CS    bus access strobe
//   BUS_RDY   bus access complete
//   BUSY      transfer in progress
// ---------------------------------------------------------------------------
module scu_dsp_dma_ctrl #(
    parameter int ADDR_W = 25
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,

    input  logic [31:0]       DSO,
    input  logic              RA0W,
    input  logic              WA0W,

    input  logic [2:0]        ADD,
    input  logic              DSP_REQ,
    input  logic              DSP_WE,
    input  logic              DSP_LAST,
    input  logic [31:0]       DSP_DI,
    output logic [31:0]       DSP_DO,
    output logic              DSP_ACK,
    output logic              DSP_END,

    output logic              BUS_REQ,
    input  logic              BUS_GNT,
    output logic [ADDR_W+1:0] BUS_A,
    output logic [31:0]       BUS_DO,
    input  logic [31:0]       BUS_DI,
    output logic              BUS_WE,
    output logic              BUS_CS,
    input  logic              BUS_RDY,

    output logic              BUSY
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StArb  = 3'd1;
    localparam logic [2:0] StAcc  = 3'd2;
    localparam logic [2:0] StAck  = 3'd3;
    localparam logic [2:0] StWait = 3'd4;
    localparam logic [2:0] StEnd  = 3'd5;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]        state_q,   state_d;
    logic              dir_q,     dir_d;
    logic              last_q,    last_d;
    logic [ADDR_W-1:0] step_q,    step_d;
    logic [ADDR_W-1:0] wadr_q,    wadr_d;
    logic [ADDR_W-1:0] ra0_q,     ra0_d;
    logic [ADDR_W-1:0] wa0_q,     wa0_d;

    logic [31:0]       dsp_do_q,  dsp_do_d;
    logic              dsp_ack_q, dsp_ack_d;
    logic              dsp_end_q, dsp_end_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W+1:0] bus_a_q,   bus_a_d;
    logic [31:0]       bus_do_q,  bus_do_d;
    logic              bus_we_q,  bus_we_d;
    logic              bus_cs_q,  bus_cs_d;
    logic              busy_q,    busy_d;

    // Write-back strobe from the END state into RA0/WA0.
    logic              wb_en;

    // Step decode: 0 for ADD=0, otherwise 1 << (ADD-1) words.
    logic [ADDR_W-1:0] step_new;

    always_comb begin
        step_new = '0;
        if (ADD != 3'd0) begin
            step_new = ADDR_W'(1) << (ADD - 3'd1);
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer next-state and registered-output next values
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        last_d    = last_q;
        step_d    = step_q;
        wadr_d    = wadr_q;
        dsp_do_d  = dsp_do_q;
        bus_req_d = bus_req_q;
        bus_a_d   = bus_a_q;
        bus_do_d  = bus_do_q;
        bus_we_d  = bus_we_q;
        bus_cs_d  = bus_cs_q;
        busy_d    = busy_q;
        // ACK and END are single-cycle pulses.
        dsp_ack_d = 1'b0;
        dsp_end_d = 1'b0;
        wb_en     = 1'b0;

        case (state_q)
            StIdle: begin
                if (DSP_REQ) begin
                    dir_d     = DSP_WE;
                    step_d    = step_new;
                    wadr_d    = DSP_WE ? wa0_q : ra0_q;
                    last_d    = DSP_LAST;
                    bus_req_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = StArb;
                end
            end

            StArb: begin
                if (BUS_GNT) begin
                    // Address, direction and write data are frozen for the
                    // whole access.
                    bus_cs_d = 1'b1;
                    bus_a_d  = {wadr_q, 2'b00};
                    bus_we_d = dir_q;
                    bus_do_d = DSP_DI;
                    state_d  = StAcc;
                end
            end

            StAcc: begin
                // Grant is not re-checked here; only RDY ends the access.
                if (BUS_RDY) begin
                    bus_cs_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_req_d = 1'b0;
                    dsp_ack_d = 1'b1;
                    if (!dir_q) begin
                        dsp_do_d = BUS_DI;
                    end
                    state_d = StAck;
                end
            end

            StAck: begin
                // Wraps silently modulo 2^ADDR_W.
                wadr_d = wadr_q + step_q;
                if (last_q) begin
                    dsp_end_d = 1'b1;
                    state_d   = StEnd;
                end else begin
                    state_d = StWait;
                end
            end

            StWait: begin
                // Direction, step and working address carry over; only the
                // LAST flag belongs to the new word.
                if (DSP_REQ) begin
                    last_d    = DSP_LAST;
                    bus_req_d = 1'b1;
                    state_d   = StArb;
                end
            end

            StEnd: begin
                wb_en   = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Architectural address registers. A DSP load strobe wins over the END
    // write-back when both target the same register in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        ra0_d = ra0_q;
        if (RA0W) begin
            ra0_d = DSO[ADDR_W-1:0];
        end else if (wb_en && !dir_q) begin
            ra0_d = wadr_q;
        end
    end

    always_comb begin
        wa0_d = wa0_q;
        if (WA0W) begin
            wa0_d = DSO[ADDR_W-1:0];
        end else if (wb_en && dir_q) begin
            wa0_d = wadr_q;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            last_q    <= 1'b0;
            step_q    <= '0;
            wadr_q    <= '0;
            ra0_q     <= '0;
            wa0_q     <= '0;
            dsp_do_q  <= '0;
            dsp_ack_q <= 1'b0;
            dsp_end_q <= 1'b0;
            bus_req_q <= 1'b0;
            bus_a_q   <= '0;
            bus_do_q  <= '0;
            bus_we_q  <= 1'b0;
            bus_cs_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else if (CE) begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_q    <= last_d;
            step_q    <= step_d;
            wadr_q    <= wadr_d;
            ra0_q     <= ra0_d;
            wa0_q     <= wa0_d;
            dsp_do_q  <= dsp_do_d;
            dsp_ack_q <= dsp_ack_d;
            dsp_end_q <= dsp_end_d;
            bus_req_q <= bus_req_d;
            bus_a_q   <= bus_a_d;
            bus_do_q  <= bus_do_d;
            bus_we_q  <= bus_we_d;
            bus_cs_q  <= bus_cs_d;
            busy_q    <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign DSP_DO  = dsp_do_q;
    assign DSP_ACK = dsp_ack_q;
    assign DSP_END = dsp_end_q;
    assign BUS_REQ = bus_req_q;
    assign BUS_A   = bus_a_q;
    assign BUS_DO  = bus_do_q;
    assign BUS_WE  = bus_we_q;
    assign BUS_CS  = bus_cs_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_scu_dsp_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scu_dsp_dma_ctrl
//
// Scoreboard bench for scu_dsp_dma_ctrl. A DSP-side driver issues transfers
// and pushes the expected bus accesses (computed from RA0/WA0, the step code
// and the word index) into a queue; a bus responder answers GNT/RDY with
// configurable or random delays; an independent monitor pops and checks each
// access, the ACK/END/BUSY timing and the read data returned to the DSP.
// ---------------------------------------------------------------------------
module tb_scu_dsp_dma_ctrl;

    localparam int ADDR_W = 25;

    logic              CLK;
    logic              RST;
    logic              CE;
    logic [31:0]       DSO;
    logic              RA0W;
    logic              WA0W;
    logic [2:0]        ADD;
    logic              DSP_REQ;
    logic              DSP_WE;
    logic              DSP_LAST;
    logic [31:0]       DSP_DI;
    logic [31:0]       DSP_DO;
    logic              DSP_ACK;
    logic              DSP_END;
    logic              BUS_REQ;
    logic              BUS_GNT;
    logic [ADDR_W+1:0] BUS_A;
    logic [31:0]       BUS_DO;
    logic [31:0]       BUS_DI;
    logic              BUS_WE;
    logic              BUS_CS;
    logic              BUS_RDY;
    logic              BUSY;

    scu_dsp_dma_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .DSO(DSO), .RA0W(RA0W), .WA0W(WA0W),
        .ADD(ADD), .DSP_REQ(DSP_REQ), .DSP_WE(DSP_WE), .DSP_LAST(DSP_LAST),
        .DSP_DI(DSP_DI), .DSP_DO(DSP_DO), .DSP_ACK(DSP_ACK), .DSP_END(DSP_END),
        .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT), .BUS_A(BUS_A), .BUS_DO(BUS_DO),
        .BUS_DI(BUS_DI), .BUS_WE(BUS_WE), .BUS_CS(BUS_CS), .BUS_RDY(BUS_RDY),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W+1:0] a;
        logic              we;
        logic [31:0]       d;
        logic              last;
    } acc_t;

    acc_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ends_exp  = 0;
    int ends_seen = 0;

    logic [ADDR_W-1:0] ra0_m = '0;
    logic [ADDR_W-1:0] wa0_m = '0;

    logic ce_rand   = 1'b0;
    int   fixed_gnt = 0;
    int   fixed_rdy = 0;
    int   min_arb   = 1;
    int   min_cs    = 1;
    logic rst_flag  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next negedge on which CE is driven high; inputs set by
    // the caller afterwards are consumed by exactly one CE edge.
    task automatic next_ce();
        do begin
            @(negedge CLK);
            CE = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end while (!CE);
    endtask

    // -----------------------------------------------------------------------
    // Bus responder
    // -----------------------------------------------------------------------
    initial begin
        int gcnt, gdly, rcnt, rdly;
        logic fresh;
        BUS_GNT = 1'b0;
        BUS_RDY = 1'b0;
        BUS_DI  = '0;
        gcnt = 0; gdly = 0; rcnt = 0; rdly = 0; fresh = 1'b1;
        forever begin
            @(negedge CLK);
            #1;
            if (!BUS_REQ) begin
                BUS_GNT = 1'b0;
                gcnt = 0;
                gdly = (fixed_gnt >= 0) ? fixed_gnt : $urandom_range(0, 3);
            end else if (!BUS_CS) begin
                if (gcnt >= gdly) BUS_GNT = 1'b1;
                else gcnt++;
            end else begin
                // Grant may drop mid-access; the DUT must not care.
                BUS_GNT = 1'($urandom);
            end
            if (!BUS_CS) begin
                BUS_RDY = 1'b0;
                rcnt = 0;
                fresh = 1'b1;
            end else begin
                if (fresh) begin
                    BUS_DI = $urandom;
                    rdly = (fixed_rdy >= 0) ? fixed_rdy : $urandom_range(0, 3);
                    fresh = 1'b0;
                end
                if (rcnt >= rdly) BUS_RDY = 1'b1;
                else rcnt++;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    initial begin
        acc_t cur;
        logic in_acc, ack_due, end_due, prev_end, cur_last, nxt_end;
        logic [31:0] exp_do;
        int arb_cyc, cs_cyc;
        in_acc = 0; ack_due = 0; end_due = 0; prev_end = 0; cur_last = 0;
        exp_do = '0; arb_cyc = 0; cs_cyc = 0;
        cur = '{a: '0, we: 1'b0, d: '0, last: 1'b0};
        forever begin
            @(negedge CLK);
            #2;
            if (RST || rst_flag) begin
                in_acc = 0; ack_due = 0; end_due = 0; prev_end = 0;
                exp_do = '0; arb_cyc = 0; cs_cyc = 0;
                rst_flag = 1'b0;
                continue;
            end
            if (!CE) continue;

            if (DSP_ACK || ack_due) begin
                check("ack_after_rdy", DSP_ACK, ack_due);
                if (DSP_ACK) check("dsp_do", DSP_DO, exp_do);
            end
            nxt_end = DSP_ACK && ack_due && cur_last;
            if (DSP_END || end_due) check("end_after_last_ack", DSP_END, end_due);
            if (DSP_END) ends_seen++;
            if (prev_end) check("busy_falls_after_end", BUSY, 1'b0);
            prev_end = DSP_END;
            end_due  = nxt_end;
            ack_due  = 1'b0;

            if (BUS_CS) begin
                check("cs_with_req_busy", {BUS_REQ, BUSY}, 2'b11);
                if (!in_acc) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_access: got addr 0x%0h, expected none", BUS_A);
                        cur = '{a: BUS_A, we: BUS_WE, d: BUS_DO, last: 1'b0};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    in_acc = 1'b1;
                    cs_cyc = 0;
                    if (!ce_rand) check("arb_length_ok", (arb_cyc >= min_arb), 1'b1);
                end
                check("bus_a", BUS_A, cur.a);
                check("bus_we", BUS_WE, cur.we);
                if (cur.we) check("bus_do", BUS_DO, cur.d);
                cs_cyc++;
                if (BUS_RDY) begin
                    in_acc   = 1'b0;
                    ack_due  = 1'b1;
                    cur_last = cur.last;
                    if (!cur.we) exp_do = BUS_DI;
                    if (!ce_rand) check("cs_length_ok", (cs_cyc >= min_cs), 1'b1);
                end
                arb_cyc = 0;
            end else if (BUS_REQ) begin
                arb_cyc++;
            end else begin
                arb_cyc = 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // DSP-side driver and reference model
    // -----------------------------------------------------------------------
    task automatic load_reg(input logic wr, input logic [31:0] val);
        next_ce();
        RA0W = !wr;
        WA0W = wr;
        DSO  = val;
        next_ce();
        RA0W = 1'b0;
        WA0W = 1'b0;
        DSO  = $urandom;
        if (wr) wa0_m = val[ADDR_W-1:0];
        else    ra0_m = val[ADDR_W-1:0];
    endtask

    // One DMA transfer of n words. st_mid strobes the direction's address
    // register during the first access; st_end strobes it on the END cycle.
    task automatic xfer(input logic dir, input logic [2:0] add, input int n,
                        input logic st_mid, input logic st_end, input logic [31:0] st_val);
        logic [ADDR_W-1:0] base, step, a;
        logic mid_done;
        int b;
        base = dir ? wa0_m : ra0_m;
        step = (add == 3'd0) ? '0 : (ADDR_W'(1) << (add - 3'd1));
        mid_done = 1'b0;
        for (int k = 0; k < n; k++) begin
            next_ce();
            RA0W = 1'b0;
            WA0W = 1'b0;
            DSP_REQ  = 1'b1;
            DSP_LAST = (k == n - 1);
            DSP_DI   = $urandom;
            if (k == 0) begin
                DSP_WE = dir;
                ADD    = add;
            end else begin
                // Ignored after the first word.
                DSP_WE = 1'($urandom);
                ADD    = 3'($urandom);
            end
            a = base + step * ADDR_W'(k);
            exp_q.push_back('{a: {a, 2'b00}, we: dir, d: DSP_DI, last: (k == n - 1)});
            next_ce();
            DSP_REQ = 1'b0;
            DSP_WE  = 1'($urandom);
            ADD     = 3'($urandom);
            check("req_to_bus_req", BUS_REQ, 1'b1);
            b = 0;
            while (!DSP_ACK && b < 400) begin
                next_ce();
                RA0W = 1'b0;
                WA0W = 1'b0;
                DSO  = $urandom;
                if (st_mid && !mid_done && BUS_CS) begin
                    RA0W = !dir;
                    WA0W = dir;
                    DSO  = st_val;
                    mid_done = 1'b1;
                end
                b++;
            end
            check("ack_seen", DSP_ACK, 1'b1);
        end
        next_ce();
        RA0W = 1'b0;
        WA0W = 1'b0;
        check("end_pulse", DSP_END, 1'b1);
        if (st_end) begin
            RA0W = !dir;
            WA0W = dir;
            DSO  = st_val;
        end
        next_ce();
        RA0W = 1'b0;
        WA0W = 1'b0;
        DSO  = $urandom;
        check("busy_low", BUSY, 1'b0);
        ends_exp++;
        a = base + step * ADDR_W'(n);
        if (st_end) a = st_val[ADDR_W-1:0];
        if (dir) wa0_m = a;
        else     ra0_m = a;
    endtask

    task automatic reset_mid_access();
        int b;
        next_ce();
        DSP_REQ = 1'b1; DSP_WE = 1'b0; ADD = 3'd1; DSP_LAST = 1'b0; DSP_DI = $urandom;
        exp_q.push_back('{a: {ra0_m, 2'b00}, we: 1'b0, d: DSP_DI, last: 1'b0});
        next_ce();
        DSP_REQ = 1'b0;
        b = 0;
        while (!BUS_CS && b < 100) begin
            next_ce();
            b++;
        end
        check("cs_before_reset", BUS_CS, 1'b1);
        #3 RST = 1'b1;
        #1;
        check("rst_dsp_do", DSP_DO, '0);
        check("rst_bus_do", BUS_DO, '0);
        check("rst_ctrl", {DSP_ACK, DSP_END, BUS_REQ, BUS_A, BUS_WE, BUS_CS, BUSY}, '0);
        exp_q.delete();
        rst_flag = 1'b1;
        ra0_m = '0;
        wa0_m = '0;
        #2 RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            next_ce();
            check("quiet_after_rst", {BUSY, DSP_ACK, DSP_END, BUS_REQ}, '0);
        end
    endtask

    initial begin
        RST = 1'b0; CE = 1'b0; DSO = '0; RA0W = 1'b0; WA0W = 1'b0; ADD = '0;
        DSP_REQ = 1'b0; DSP_WE = 1'b0; DSP_LAST = 1'b0; DSP_DI = '0;
        #1 RST = 1'b1;
        #2;
        check("reset_dsp_do", DSP_DO, '0);
        check("reset_bus_do", BUS_DO, '0);
        check("reset_ctrl", {DSP_ACK, DSP_END, BUS_REQ, BUS_A, BUS_WE, BUS_CS, BUSY}, '0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Read, step 1, three words from RA0=0x100.
        load_reg(1'b0, 32'h100);
        xfer(1'b0, 3'd1, 3, 1'b0, 1'b0, '0);
        check("ra0_after_read", ra0_m, 25'h103);
        // Write, step 0, address stays put.
        load_reg(1'b1, 32'h20);
        xfer(1'b1, 3'd0, 2, 1'b0, 1'b0, '0);
        // Write, step 64 words, wraps at 2^25.
        load_reg(1'b1, 32'h1FF_FFC0);
        xfer(1'b1, 3'd7, 2, 1'b0, 1'b0, '0);
        // Confirms WA0 = 0x40 through the next transfer's address.
        xfer(1'b1, 3'd0, 1, 1'b0, 1'b0, '0);
        // Slow arbiter and slow slave.
        fixed_gnt = 5; fixed_rdy = 3; min_arb = 5; min_cs = 3;
        xfer(1'b0, 3'd2, 2, 1'b0, 1'b0, '0);
        fixed_gnt = 0; fixed_rdy = 0; min_arb = 1; min_cs = 1;
        // RA0 strobes during the access and on END; strobe wins.
        xfer(1'b0, 3'd1, 2, 1'b1, 1'b1, 32'h55);
        xfer(1'b0, 3'd0, 1, 1'b0, 1'b0, '0);
        // Only the mid-access strobe: write-back overrides it.
        xfer(1'b0, 3'd3, 2, 1'b1, 1'b0, 32'h777);
        xfer(1'b0, 3'd0, 1, 1'b0, 1'b0, '0);
        // Reset in the middle of an access, then a clean restart.
        reset_mid_access();
        xfer(1'b0, 3'd1, 2, 1'b0, 1'b0, '0);

        // Randomised traffic with gapped CE and random bus latencies.
        ce_rand = 1'b1; fixed_gnt = -1; fixed_rdy = -1;
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 2) == 0) load_reg(1'($urandom), $urandom);
            xfer(1'($urandom), 3'($urandom), $urandom_range(1, 4),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
        end
        ce_rand = 1'b0;
        repeat (5) next_ce();
        check("queue_drained", exp_q.size(), 0);
        check("end_count", ends_seen, ends_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
